// File: rtl/tape_ctrl_pkg.sv
// rtl/tape_ctrl_pkg.sv - shared op/state encodings and default widths for the tape controller
//
// Purpose: op encoding seen on the decoder command port, controller state
// encoding, and the default cell/pointer widths shared with the tape RAM.

package tape_ctrl_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int SIZE_WIDTH = 6;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_INC   = 3'd1,
      OP_DEC   = 3'd2,
      OP_RIGHT = 3'd3,
      OP_LEFT  = 3'd4,
      OP_OUT   = 3'd5,
      OP_IN    = 3'd6,
      OP_RSVD  = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OUT_WAIT = 2'd1,
      ST_IN_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/tape_ctrl.sv
// rtl/tape_ctrl.sv - data-tape controller: owns the data pointer and executes + - > < . ,
//
// Purpose: initiator side of the data-tape RAM. Executes tape ops from the
// decoder, drives RAM address/write data, and reports cell_zero to the
// branch logic.
// Ports:
//   clk, nrst                     clock, async active-low reset (shared with RAM)
//   cmd_valid/ready, cmd_op/arg   decoder command handshake
//   out_valid/ready, out_data     console output byte
//   in_valid/ready, in_data       console input byte
//   ram_addr/wdata, ram_rdata     tape RAM (written every cycle, combinational read)
//   ptr, cell_zero, busy          status for the branch logic

module tape_ctrl
   import tape_ctrl_pkg::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int size_width = SIZE_WIDTH
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [2:0]            cmd_op,
   input  logic [data_width-1:0] cmd_arg,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   output logic [size_width-1:0] ram_addr,
   output logic [data_width-1:0] ram_wdata,
   input  logic [data_width-1:0] ram_rdata,
   output logic [size_width-1:0] ptr,
   output logic                  cell_zero,
   output logic                  busy
);

   state_t                state;
   op_t                   op;
   logic                  accept;
   logic [size_width-1:0] step;

   assign op        = op_t'(cmd_op);
   assign cmd_ready = (state == ST_IDLE);
   assign accept    = cmd_valid & cmd_ready;
   assign ram_addr  = ptr;
   assign cell_zero = (ram_rdata == '0);
   // Pointer moves use only the low bits of the count; wrap is implicit.
   assign step      = cmd_arg[size_width-1:0];

   // The RAM writes every edge, so by default write the cell back unchanged.
   always_comb begin
      ram_wdata = ram_rdata;
      if (accept) begin
         case (op)
            OP_INC:  ram_wdata = ram_rdata + cmd_arg;
            OP_DEC:  ram_wdata = ram_rdata - cmd_arg;
            default: ram_wdata = ram_rdata;
         endcase
      end else if (state == ST_IN_WAIT && in_valid) begin
         ram_wdata = in_data;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (op)
                     OP_RIGHT: ptr <= ptr + step;
                     OP_LEFT:  ptr <= ptr - step;
                     OP_OUT: begin
                        out_data  <= ram_rdata;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_OUT_WAIT;
                     end
                     OP_IN: begin
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_IN_WAIT;
                     end
                     default: ;
                  endcase
               end
            end
            ST_OUT_WAIT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_IN_WAIT: begin
               // The cell write itself happens through ram_wdata this cycle.
               if (in_valid) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tape_ctrl.sv
// tb/tb_tape_ctrl.sv - scoreboard bench for tape_ctrl with a tape RAM and reference model

module tb_tape_ctrl;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_arg = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'd0;
   logic [5:0] ram_addr;
   logic [7:0] ram_wdata;
   logic [7:0] ram_rdata;
   logic [5:0] ptr;
   logic       cell_zero;
   logic       busy;

   always #5 clk = ~clk;

   tape_ctrl #(.data_width(8), .size_width(6)) dut (
      .clk(clk), .nrst(nrst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .ptr(ptr), .cell_zero(cell_zero), .busy(busy)
   );

   // Tape RAM: cleared by the shared reset, written every edge, combinational read.
   logic [7:0] mem [64];
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'd0;
      end else begin
         mem[ram_addr] <= ram_wdata;
      end
   end
   assign ram_rdata = mem[ram_addr];

   // Reference model: the tape as plain integers plus a pointer.
   int ref_tape [64];
   int ref_ptr;

   typedef struct {int p; int c;} snap_t;
   snap_t exp_stat [$];
   int    exp_out  [$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a completion seen at one negedge is checked at the next one.
   bit pending = 0;
   always @(negedge clk) begin
      snap_t s;
      if (!nrst) begin
         pending = 0;
      end else begin
         if (pending) begin
            if (exp_stat.size() == 0) begin
               chk("stat_underflow", 1, 0);
            end else begin
               s = exp_stat.pop_front();
               chk("ptr", ptr, s.p);
               chk("ram_addr", ram_addr, s.p);
               chk("cell", ram_rdata, s.c);
               chk("cell_zero", cell_zero, (s.c == 0) ? 1 : 0);
               chk("busy_after_op", busy, 0);
            end
            pending = 0;
         end
         if (cmd_valid && cmd_ready && cmd_op != 3'd5 && cmd_op != 3'd6) pending = 1;
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) chk("out_underflow", 1, 0);
            else chk("out_data", out_data, exp_out.pop_front());
            pending = 1;
         end
         if (in_valid && in_ready) pending = 1;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_tape[i] = 0;
      ref_ptr = 0;
   endtask

   task automatic issue(input int op, input int arg);
      int t = 0;
      case (op)
         1: ref_tape[ref_ptr] = (ref_tape[ref_ptr] + arg) % 256;
         2: ref_tape[ref_ptr] = (ref_tape[ref_ptr] + 256 - arg) % 256;
         3: ref_ptr = (ref_ptr + arg) % 64;
         4: ref_ptr = (ref_ptr + 64 - (arg % 64)) % 64;
         5: exp_out.push_back(ref_tape[ref_ptr]);
         default: ;
      endcase
      if (op != 6) exp_stat.push_back('{ref_ptr, ref_tape[ref_ptr]});
      cmd_op = op[2:0];
      cmd_arg = arg[7:0];
      cmd_valid = 1'b1;
      while (!cmd_ready && t < 50) begin
         @(posedge clk); #1; t++;
      end
      if (t >= 50) chk("cmd_ready_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
      cmd_arg = 8'd0;
   endtask

   task automatic do_out(input int stall);
      int exp_byte;
      exp_byte = ref_tape[ref_ptr];
      issue(5, $urandom_range(0, 255));
      for (int i = 0; i < stall; i++) begin
         chk("out_valid_hold", out_valid, 1);
         chk("out_data_hold", out_data, exp_byte);
         chk("cmd_ready_out_wait", cmd_ready, 0);
         chk("busy_out_wait", busy, 1);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
      chk("cmd_ready_after_out", cmd_ready, 1);
   endtask

   task automatic do_in(input int stall, input int data);
      issue(6, $urandom_range(0, 255));
      for (int i = 0; i < stall; i++) begin
         chk("in_ready_wait", in_ready, 1);
         chk("busy_in_wait", busy, 1);
         chk("cmd_ready_in_wait", cmd_ready, 0);
         @(posedge clk); #1;
      end
      ref_tape[ref_ptr] = data;
      exp_stat.push_back('{ref_ptr, data});
      in_data = data[7:0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_ready_drop", in_ready, 0);
   endtask

   task automatic idle_noise();
      in_data = 8'($urandom_range(0, 255));
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int op;
      model_reset();
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      chk("rst_ptr", ptr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_cell_zero", cell_zero, 1);

      // Directed sequence.
      issue(1, 3);
      issue(2, 3);
      issue(2, 1);
      issue(1, 2);
      issue(4, 1);
      issue(3, 2);
      @(posedge clk); #1;
      chk("cell0_after_moves", mem[0], 1);
      chk("cell63_after_moves", mem[63], 0);
      issue(1, 8'h41);
      do_out(3);
      do_in(2, 8'h7A);
      idle_noise();
      idle_noise();
      chk("cell_after_idle_in", ram_rdata, 8'h7A);
      issue(0, 5);
      issue(7, 9);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 7);
         if (op == 5) do_out($urandom_range(0, 3));
         else if (op == 6) do_in($urandom_range(0, 3), $urandom_range(0, 255));
         else issue(op, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) idle_noise();
      end
      repeat (3) @(posedge clk); #1;
      for (int i = 0; i < 64; i++) chk("tape_final", mem[i], ref_tape[i]);
      chk("exp_out_drained", exp_out.size(), 0);
      chk("exp_stat_drained", exp_stat.size(), 0);

      // Reset while waiting for an input byte.
      issue(3, 5);
      issue(1, 9);
      issue(6, 0);
      @(posedge clk); #1;
      @(posedge clk); #2;
      nrst = 1'b0;
      #1;
      model_reset();
      chk("midrst_ptr", ptr, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      @(posedge clk); #1;
      nrst = 1'b1;
      for (int i = 0; i < 64; i++) chk("midrst_tape", mem[i], 0);
      chk("midrst_cell_zero", cell_zero, 1);
      issue(1, 1);
      repeat (2) @(posedge clk); #1;
      chk("post_rst_stat_drained", exp_stat.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tape_ctrl.md
Name: tape_ctrl

Overview:
Initiator side of the data-tape RAM interface for the brainfuck CPU.
- Owns the data pointer and executes tape-side ops from the decoder: + - > < . ,
- Drives the RAM's address and write-data lines and consumes its combinational read data.
- Gives the branch logic a cell-is-zero flag for [ and ].

Parameters:
- data_width, 8, cell width in bits; must equal the RAM data_width.
- size_width, 6, pointer width; the tape holds 2^size_width cells.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nrst  in  1  asynchronous active-low reset; shared with the RAM.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  controller accepts the command this cycle.
- cmd_op  in  3  0 NOP, 1 INC, 2 DEC, 3 RIGHT, 4 LEFT, 5 OUT, 6 IN, 7 reserved (treated as NOP).
- cmd_arg  in  data_width  repeat count for INC/DEC/RIGHT/LEFT (run-length folded); ignored for other ops.
- out_valid  out  1  out_data holds a byte for the console.
- out_ready  in  1  console takes the byte.
- out_data  out  data_width  byte emitted by OUT.
- in_valid  in  1  console offers an input byte.
- in_ready  out  1  controller waits for an input byte.
- in_data  in  data_width  byte to be stored by IN.
- ram_addr  out  size_width  RAM address; always equals ptr.
- ram_wdata  out  data_width  RAM write data; the RAM writes it on every clock edge.
- ram_rdata  in  data_width  combinational RAM read at ram_addr.
- ptr  out  size_width  current data pointer.
- cell_zero  out  1  high when ram_rdata == 0 (combinational).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, nrst low) sets:
  - ptr = 0, state = IDLE
  - out_valid = 0, out_data = 0, in_ready = 0, busy = 0
  - The RAM clears on the same reset, so cell_zero = 1 after reset.
- The RAM writes every cycle, so ram_wdata defaults to ram_rdata (write-back hold). It differs only on an INC/DEC accept cycle or an IN completion cycle.
- States are IDLE, OUT_WAIT and IN_WAIT. cmd_ready = (state == IDLE).
- Each of the following completes in its accept cycle and stays in IDLE (cmd_valid & cmd_ready):
  - INC: ram_wdata = ram_rdata + cmd_arg, modulo 2^data_width.
  - DEC: ram_wdata = ram_rdata - cmd_arg, modulo 2^data_width.
  - RIGHT: ptr <= ptr + cmd_arg[size_width-1:0], modulo 2^size_width. The cell is unchanged.
  - LEFT: ptr <= ptr - cmd_arg[size_width-1:0], modulo 2^size_width. The cell is unchanged.
  - NOP and op 7: no effect.
- An arg of 0 is legal and is a no-op.
- INC/DEC followed immediately by another command sees the updated cell next cycle (RAM read is combinational).
- OUT:
  - On accept: out_data <= ram_rdata, out_valid <= 1, state becomes OUT_WAIT.
  - In OUT_WAIT, when out_ready is high: out_valid <= 0, state becomes IDLE.
  - Total: 1 accept cycle plus at least 1 handshake cycle. out_data holds stable while out_valid is high.
- IN:
  - On accept: in_ready <= 1, state becomes IN_WAIT.
  - In IN_WAIT with in_valid: ram_wdata = in_data (written at that edge), in_ready <= 0, state becomes IDLE.
  - in_valid outside IN_WAIT is ignored and nothing is consumed.
- Pointer wrap: > at ptr 2^size_width-1 goes to 0; < at ptr 0 goes to 2^size_width-1.
- cell_zero and ptr are valid in every state. Branch logic samples them only while busy = 0.
- Reset mid-operation:
  - From IN_WAIT: returns to IDLE with no cell write; the tape is cleared anyway.
  - From OUT_WAIT: drops out_valid and the byte is lost.
- cmd_valid without cmd_ready: the command is not consumed and the decoder holds it.

Decomposition:
- A shared package holds:
  - the op encoding enum (3 bits, values above)
  - the state enum (IDLE, OUT_WAIT, IN_WAIT)
  - the default widths 8 and 6, shared with the RAM instantiation.
- No sub-module; the datapath is one adder/subtractor per register and a mux on ram_wdata. Keep the block flat.

Test Plan:
- Reset, then INC arg 3 → ram cell 0 = 3, cell_zero = 0, ptr = 0. Then DEC arg 3 → cell = 0, cell_zero = 1.
- DEC arg 1 on a zero cell → cell = 0xFF. INC arg 2 → 0x01 (data wrap).
- LEFT arg 1 at ptr 0 → ptr = 63. RIGHT arg 2 → ptr = 1. Cells 63 and 0 are unchanged by the moves.
- INC arg 0x41, OUT with out_ready held low 3 cycles → out_valid = 1 and out_data = 0x41 stable; cmd_ready = 0 and busy = 1 throughout. Release out_ready → one transfer, then IDLE.
- IN with in_valid low 2 cycles, then in_data = 0x7A with in_valid = 1 → cell = 0x7A next cycle, in_ready drops. in_valid pulses while IDLE leave the cell unchanged.
- Assert nrst low during IN_WAIT → ptr = 0, in_ready = 0, state IDLE, all cells 0, cmd_ready = 1 after release.
